// File: rtl/apb_timer_pkg.sv
// Shared register map and bit positions for the APB timer slave.
// Capture option is selected with APB_TIMER_CAPTURE_EN.
package apb_timer_pkg;

  localparam logic [2:0] OFS_CTRL    = 3'd0;
  localparam logic [2:0] OFS_LOAD    = 3'd1;
  localparam logic [2:0] OFS_VALUE   = 3'd2;
  localparam logic [2:0] OFS_STATUS  = 3'd3;
  localparam logic [2:0] OFS_CAPTURE = 3'd4;

  localparam int CTRL_EN        = 0;
  localparam int CTRL_PERIODIC  = 1;
  localparam int CTRL_IRQ_EN    = 2;
  localparam int CTRL_PRESC_LSB = 8;
  localparam int CTRL_PRESC_MSB = 15;

  localparam int STAT_EXPIRED = 0;
  localparam int STAT_CAPF    = 1;

endpackage

// File: rtl/apb_timer_prescaler.sv
// Free-running 0..presc divider producing a one-cycle tick.
// Held at zero while disabled or restarted.
module apb_timer_prescaler #(
  parameter int PRESC_W = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               enable_i,
  input  logic               restart_i,
  input  logic [PRESC_W-1:0] presc_i,
  output logic               tick_o
);

  logic [PRESC_W-1:0] cnt_q, cnt_d;

  assign tick_o = enable_i && (cnt_q == presc_i);

  always_comb begin
    cnt_d = cnt_q + PRESC_W'(1);
    if (!enable_i || restart_i || tick_o) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/apb_timer_slave.sv
// Zero-wait APB2 down-counter timer with prescaler and level IRQ.
// APB_TIMER_CAPTURE_EN adds CAP_IN edge capture at offset 0x10.
module apb_timer_slave
  import apb_timer_pkg::*;
#(
  parameter int PRESC_W = 8,
  parameter int CNT_W   = 32
) (
  input  logic        HCLK,
  input  logic        HRESETn,
  input  logic        PSEL,
  input  logic        PENABLE,
  input  logic        PWRITE,
  input  logic [31:0] PADDR,
  input  logic [31:0] PWDATA,
`ifdef APB_TIMER_CAPTURE_EN
  input  logic        CAP_IN,
`endif
  output logic [31:0] PRDATA,
  output logic        IRQ
);

  logic [2:0] sel;
  logic       wr, wr_ctrl, wr_load, wr_status;
  logic       tick, restart, cnt_step, expire;

  logic               en_q, en_d;
  logic               per_q, per_d;
  logic               irq_en_q, irq_en_d;
  logic [PRESC_W-1:0] presc_q, presc_d;
  logic [CNT_W-1:0]   load_q, load_d;
  logic [CNT_W-1:0]   value_q, value_d;
  logic               exp_q, exp_d;

  logic        capf;
  logic [31:0] capture_rd;
  logic [31:0] ctrl_rd;

  logic unused_paddr;
  assign unused_paddr = ^{PADDR[31:5], PADDR[1:0]};

  assign sel       = PADDR[4:2];
  assign wr        = PSEL && PENABLE && PWRITE;
  assign wr_ctrl   = wr && (sel == OFS_CTRL);
  assign wr_load   = wr && (sel == OFS_LOAD);
  assign wr_status = wr && (sel == OFS_STATUS);

  // Restart on LOAD writes and on an EN 0->1 write.
  assign restart = wr_load
                || (wr_ctrl && PWDATA[CTRL_EN] && !en_q);

  apb_timer_prescaler #(
    .PRESC_W (PRESC_W)
  ) u_presc (
    .clk       (HCLK),
    .rst_n     (HRESETn),
    .enable_i  (en_q),
    .restart_i (restart),
    .presc_i   (presc_q),
    .tick_o    (tick)
  );

  // A LOAD write or an EN-clearing CTRL write suppresses the tick.
  assign cnt_step = tick && en_q && !wr_load
                 && !(wr_ctrl && !PWDATA[CTRL_EN]);
  assign expire   = cnt_step && (value_q == '0);

  always_comb begin
    en_d     = en_q;
    per_d    = per_q;
    irq_en_d = irq_en_q;
    presc_d  = presc_q;
    load_d   = load_q;
    value_d  = value_q;
    exp_d    = exp_q;
    if (cnt_step) begin
      if (value_q != '0) begin
        value_d = value_q - CNT_W'(1);
      end else if (per_q) begin
        value_d = load_q;
      end else begin
        en_d = 1'b0;
      end
    end
    if (wr_status && PWDATA[STAT_EXPIRED]) begin
      exp_d = 1'b0;
    end
    if (expire) begin
      exp_d = 1'b1;
    end
    if (wr_load) begin
      load_d  = PWDATA[CNT_W-1:0];
      value_d = PWDATA[CNT_W-1:0];
    end
    if (wr_ctrl) begin
      en_d     = PWDATA[CTRL_EN];
      per_d    = PWDATA[CTRL_PERIODIC];
      irq_en_d = PWDATA[CTRL_IRQ_EN];
      presc_d  = PWDATA[CTRL_PRESC_LSB +: PRESC_W];
    end
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      en_q     <= 1'b0;
      per_q    <= 1'b0;
      irq_en_q <= 1'b0;
      presc_q  <= '0;
      load_q   <= '0;
      value_q  <= '0;
      exp_q    <= 1'b0;
    end else begin
      en_q     <= en_d;
      per_q    <= per_d;
      irq_en_q <= irq_en_d;
      presc_q  <= presc_d;
      load_q   <= load_d;
      value_q  <= value_d;
      exp_q    <= exp_d;
    end
  end

`ifdef APB_TIMER_CAPTURE_EN
  logic [2:0]       cap_sync_q;
  logic             capf_q, capf_d;
  logic [CNT_W-1:0] capture_q;
  logic             cap_edge;

  assign cap_edge = cap_sync_q[1] && !cap_sync_q[2];

  always_comb begin
    capf_d = capf_q;
    if (wr_status && PWDATA[STAT_CAPF]) begin
      capf_d = 1'b0;
    end
    if (cap_edge) begin
      capf_d = 1'b1;
    end
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      cap_sync_q <= '0;
      capf_q     <= 1'b0;
      capture_q  <= '0;
    end else begin
      cap_sync_q <= {cap_sync_q[1:0], CAP_IN};
      capf_q     <= capf_d;
      if (cap_edge) begin
        capture_q <= value_q;
      end
    end
  end

  assign capf       = capf_q;
  assign capture_rd = 32'(capture_q);
`else
  assign capf       = 1'b0;
  assign capture_rd = '0;
`endif

  assign IRQ = (exp_q || capf) && irq_en_q;

  always_comb begin
    ctrl_rd = '0;
    ctrl_rd[CTRL_EN]       = en_q;
    ctrl_rd[CTRL_PERIODIC] = per_q;
    ctrl_rd[CTRL_IRQ_EN]   = irq_en_q;
    ctrl_rd[CTRL_PRESC_LSB +: PRESC_W] = presc_q;
  end

  always_comb begin
    PRDATA = '0;
    if (PSEL && !PWRITE) begin
      unique case (sel)
        OFS_CTRL:    PRDATA = ctrl_rd;
        OFS_LOAD:    PRDATA = 32'(load_q);
        OFS_VALUE:   PRDATA = 32'(value_q);
        OFS_STATUS:  PRDATA = {30'b0, capf, exp_q};
        OFS_CAPTURE: PRDATA = capture_rd;
        default:     PRDATA = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_apb_timer_slave.sv
// Self-checking bench for apb_timer_slave.
// Capture checks are built when APB_TIMER_CAPTURE_EN is defined.
module tb_apb_timer_slave;

  logic        HCLK = 1'b0;
  logic        HRESETn;
  logic        PSEL, PENABLE, PWRITE;
  logic [31:0] PADDR, PWDATA;
  logic [31:0] PRDATA;
  logic        IRQ;
`ifdef APB_TIMER_CAPTURE_EN
  logic        CAP_IN = 1'b0;
`endif

  apb_timer_slave dut (
    .HCLK    (HCLK),
    .HRESETn (HRESETn),
    .PSEL    (PSEL),
    .PENABLE (PENABLE),
    .PWRITE  (PWRITE),
    .PADDR   (PADDR),
    .PWDATA  (PWDATA),
`ifdef APB_TIMER_CAPTURE_EN
    .CAP_IN  (CAP_IN),
`endif
    .PRDATA  (PRDATA),
    .IRQ     (IRQ)
  );

  always #5 HCLK = ~HCLK;

  typedef struct packed {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] data;
    logic [31:0] exp;
  } vec_t;

  vec_t        vecs [16];
  logic [31:0] sb_q [$];
  int          n_chk = 0;
  int          n_err = 0;
  int          t;

  task automatic chk(input string nm, input logic [31:0] act);
    logic [31:0] e;
    n_chk++;
    if (sb_q.size() == 0) begin
      n_err++;
      $display("FAIL %s: got %h, no expected value queued", nm, act);
    end else begin
      e = sb_q.pop_front();
      if (act !== e) begin
        n_err++;
        $display("FAIL %s: got %h expected %h", nm, act, e);
      end
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge HCLK);
    #1;
  endtask

  task automatic apb_write(input logic [31:0] a, input logic [31:0] d);
    PSEL = 1'b1; PWRITE = 1'b1; PENABLE = 1'b0;
    PADDR = a; PWDATA = d;
    @(posedge HCLK); #1;
    PENABLE = 1'b1;
    @(posedge HCLK); #1;
    PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
  endtask

  task automatic apb_read(input logic [31:0] a, input logic [31:0] e,
                          input string nm);
    sb_q.push_back(e);
    PSEL = 1'b1; PWRITE = 1'b0; PENABLE = 1'b0; PADDR = a;
    @(posedge HCLK); #1;
    PENABLE = 1'b1;
    #1 chk(nm, PRDATA);
    @(posedge HCLK); #1;
    PSEL = 1'b0; PENABLE = 1'b0;
  endtask

  // Setup-phase-only observation: no clock edge passes.
  task automatic peek(input logic [31:0] a, input logic [31:0] e,
                      input string nm);
    sb_q.push_back(e);
    PSEL = 1'b1; PWRITE = 1'b0; PENABLE = 1'b0; PADDR = a;
    #1 chk(nm, PRDATA);
    PSEL = 1'b0; PADDR = '0;
  endtask

  task automatic chk_irq(input logic e, input string nm);
    sb_q.push_back({31'b0, e});
    chk(nm, {31'b0, IRQ});
  endtask

  task automatic run_vecs(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) begin
      if (vecs[i].wr) begin
        apb_write(vecs[i].addr, vecs[i].data);
      end else begin
        apb_read(vecs[i].addr, vecs[i].exp, $sformatf("vec%0d", i));
      end
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1);
  end

  initial begin
    vecs[0]  = '{1'b0, 32'h00, 32'h0, 32'h0};
    vecs[1]  = '{1'b0, 32'h04, 32'h0, 32'h0};
    vecs[2]  = '{1'b0, 32'h08, 32'h0, 32'h0};
    vecs[3]  = '{1'b0, 32'h0C, 32'h0, 32'h0};
    vecs[4]  = '{1'b0, 32'h10, 32'h0, 32'h0};
    vecs[5]  = '{1'b0, 32'h14, 32'h0, 32'h0};
    vecs[6]  = '{1'b1, 32'h00, 32'h0, 32'h0};
    vecs[7]  = '{1'b1, 32'h04, 32'h1234, 32'h0};
    vecs[8]  = '{1'b1, 32'h0C, 32'h3, 32'h0};
    vecs[9]  = '{1'b1, 32'h08, 32'hDEADBEEF, 32'h0};
    vecs[10] = '{1'b1, 32'h14, 32'hDEADBEEF, 32'h0};
    vecs[11] = '{1'b0, 32'h14, 32'h0, 32'h0};
    vecs[12] = '{1'b0, 32'h08, 32'h0, 32'h1234};
    vecs[13] = '{1'b0, 32'h4000_0004, 32'h0, 32'h1234};
    vecs[14] = '{1'b0, 32'h00, 32'h0, 32'h0};
    vecs[15] = '{1'b0, 32'h0C, 32'h0, 32'h0};

    HRESETn = 1'b0;
    PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
    PADDR = '0; PWDATA = '0;
    wait_cyc(2);
    for (int a = 0; a < 16; a += 4) begin
      peek(32'(a), 32'h0, $sformatf("rst_rd%0h", a));
    end
    chk_irq(1'b0, "rst_irq");
    HRESETn = 1'b1;
    wait_cyc(1);
    run_vecs(0, 5);

    // One-shot, PRESC=0
    apb_write(32'h04, 32'd3);
    apb_write(32'h00, 32'h0005);
    peek(32'h08, 32'd3, "os_v3");
    wait_cyc(1); peek(32'h08, 32'd2, "os_v2");
    wait_cyc(1); peek(32'h08, 32'd1, "os_v1");
    wait_cyc(1); peek(32'h08, 32'd0, "os_v0");
    peek(32'h0C, 32'd0, "os_st_pre");
    chk_irq(1'b0, "os_irq_pre");
    wait_cyc(1);
    peek(32'h0C, 32'd1, "os_st");
    chk_irq(1'b1, "os_irq");
    peek(32'h00, 32'h4, "os_ctrl");
    wait_cyc(1); peek(32'h08, 32'd0, "os_hold");
    apb_write(32'h0C, 32'h1);
    chk_irq(1'b0, "os_w1c_irq");
    peek(32'h0C, 32'd0, "os_w1c_st");

    // Periodic, PRESC=3, period 12
    apb_write(32'h04, 32'd2);
    apb_write(32'h00, 32'h0303);
    t = 0;
    for (int k = 1; k <= 3; k++) begin
      wait_cyc(12 * k - 1 - t);
      peek(32'h08, 32'd0, $sformatf("per%0d_v0", k));
      peek(32'h0C, 32'd0, $sformatf("per%0d_st0", k));
      wait_cyc(1);
      peek(32'h08, 32'd2, $sformatf("per%0d_rel", k));
      peek(32'h0C, 32'd1, $sformatf("per%0d_st1", k));
      apb_write(32'h0C, 32'h1);
      t = 12 * k + 2;
    end
    chk_irq(1'b0, "per_irq_off");

    // LOAD write in a tick cycle, then EN-clear in a tick cycle
    apb_write(32'h00, 32'h0003);
    apb_write(32'h04, 32'd50);
    peek(32'h08, 32'd50, "col_load");
    apb_write(32'h00, 32'h0000);
    peek(32'h08, 32'd49, "col_endis");

    // W1C in the expiry cycle
    apb_write(32'h0C, 32'h1);
    apb_write(32'h04, 32'd2);
    apb_write(32'h00, 32'h0001);
    peek(32'h0C, 32'd0, "col_st_pre");
    wait_cyc(1);
    apb_write(32'h0C, 32'h1);
    peek(32'h0C, 32'd1, "col_w1c");
    peek(32'h00, 32'd0, "col_ctrl");

    run_vecs(6, 15);

`ifdef APB_TIMER_CAPTURE_EN
    apb_write(32'h04, 32'd100);
    apb_write(32'h00, 32'h0005);
    CAP_IN = 1'b1;
    wait_cyc(2);
    peek(32'h10, 32'd0, "cap_early");
    wait_cyc(1);
    peek(32'h10, 32'd98, "cap_val");
    peek(32'h0C, 32'd2, "cap_st");
    chk_irq(1'b1, "cap_irq");
    CAP_IN = 1'b0;
    apb_write(32'h0C, 32'h2);
    chk_irq(1'b0, "cap_w1c");
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/apb_timer_slave.md
Name: apb_timer_slave

Overview:
- APB peripheral on the downstream side of the AHB-to-APB bridge. One bridge PSELx bit drives this block's PSEL; its PRDATA returns to the bridge.
- Programmable 32-bit down-counter with an 8-bit prescaler, one-shot and periodic modes, a sticky expiry flag and a level interrupt.
- Zero-wait-state APB2 slave: no PREADY and no PSLVERR, which matches the bridge.

Parameters:
- PRESC_W, 8, prescaler width; CTRL[15:8] holds the prescale value.
- CNT_W, 32, counter and LOAD width; must be ≤32, and read data is zero-extended to 32 bits.

Ports:
- HCLK  in  1  single clock, shared with the bridge.
- HRESETn  in  1  asynchronous, active-low reset.
- PSEL  in  1  slave select (one bit of bridge PSELx).
- PENABLE  in  1  APB access phase.
- PWRITE  in  1  1 = write.
- PADDR  in  32  only PADDR[4:2] are decoded; all other bits are ignored.
- PWDATA  in  32  write data.
- PRDATA  out  32  read data.
- IRQ  out  1  level interrupt.

Behaviour:
- Register map (PADDR[4:0]):
  - 0x00 CTRL, R/W: [0] EN, [1] PERIODIC, [2] IRQ_EN, [15:8] PRESC.
  - 0x04 LOAD, R/W.
  - 0x08 VALUE, read-only; writes are ignored.
  - 0x0C STATUS: [0] EXPIRED, write-1-to-clear.
  - Any other offset reads 0; writes to it are ignored.
- Write strobe: wr = PSEL & PENABLE & PWRITE. Register update happens on that HCLK edge. One write per access.
- Read data is combinational. PRDATA = selected register when PSEL & !PWRITE, otherwise 32'h0. It is valid in both setup and access phases; the bridge samples it in the access phase.
- Reset values: CTRL=0, LOAD=0, VALUE=0, STATUS=0, prescaler count=0. IRQ=0 and PRDATA=0. Reset asserted mid-count aborts immediately.
- Prescaler:
  - Counts 0..PRESC while EN=1.
  - tick=1 in the cycle the count equals PRESC; the count then wraps to 0.
  - PRESC=0 gives a tick every cycle.
  - While EN=0, the count is held at 0.
- Counter, on tick with EN=1:
  - VALUE≠0: VALUE ← VALUE−1.
  - VALUE==0: EXPIRED ← 1. If PERIODIC=1, VALUE ← LOAD. Otherwise VALUE stays 0 and EN ← 0 (one-shot stop).
  - Period is therefore (LOAD+1)·(PRESC+1) cycles.
- A LOAD write also sets VALUE ← PWDATA in the same edge and clears the prescaler count.
- A CTRL write with EN going 0→1 clears the prescaler count. The first tick then occurs PRESC+1 cycles later.
- IRQ = EXPIRED & IRQ_EN, both taken straight from flops with no extra logic, so IRQ is glitch-free.
- Simultaneous events:
  - LOAD write and tick in the same cycle: the write wins and no decrement occurs.
  - STATUS W1C and a new expiry in the same cycle: the set wins (EXPIRED=1).
  - A CTRL write clearing EN and a tick in the same cycle: the write wins and no count change occurs.
  - One-shot auto-clear of EN and a CTRL write in the same cycle: the written value wins.
- Wrap-around: VALUE never underflows; at 0 it reloads or holds.

Optional Feature:
- Macro: APB_TIMER_CAPTURE_EN.
- Defined:
  - Adds input CAP_IN (1 bit, asynchronous), with a 2-flop synchroniser plus rising-edge detector.
  - On a detected edge, CAPTURE (offset 0x10, read-only, reset 0) ← VALUE, and STATUS[1] CAPF ← 1 (W1C; set wins over clear).
  - Latency: the capture happens 3 HCLK edges after CAP_IN rises.
  - IRQ = (EXPIRED | CAPF) & IRQ_EN.
- Not defined: no CAP_IN port; 0x10 reads 0; STATUS[1] reads 0.

Decomposition:
- Package apb_timer_pkg:
  - Register offsets: OFS_CTRL, OFS_LOAD, OFS_VALUE, OFS_STATUS, OFS_CAPTURE.
  - CTRL bit indices: CTRL_EN, CTRL_PERIODIC, CTRL_IRQ_EN, CTRL_PRESC_LSB/MSB.
  - STATUS bit indices.
- Sub-module apb_timer_prescaler:
  - Inputs: enable, restart, presc.
  - Output: tick.
  - Instantiated once.

Test Plan:
- Reset: HRESETn=0 with PSEL=1 reading 0x00..0x0C → PRDATA=0 and IRQ=0. Release, then read all offsets → 0.
- One-shot: write LOAD=3, then CTRL=0x0005 (EN, IRQ_EN, PRESC=0) → VALUE 3,2,1,0 on successive cycles, then EXPIRED=1, IRQ=1, CTRL.EN=0, VALUE holds 0. W1C STATUS=1 → IRQ=0.
- Periodic with prescale: LOAD=2, CTRL=0x0303 (EN, PERIODIC, PRESC=3) → EXPIRED sets every 12 cycles and VALUE reloads to 2. Verify over 3 periods.
- Collisions: LOAD write in a tick cycle → VALUE = new LOAD with no decrement. W1C STATUS in the expiry cycle → EXPIRED stays 1.
- Decode: write 0xDEADBEEF to 0x08 and 0x14 → no state change; reads return 0 for 0x14. PADDR=0x4000_0004 reads LOAD (upper bits ignored).
- APB_TIMER_CAPTURE_EN: VALUE counting from 100 with PRESC=0; pulse CAP_IN → CAPTURE equals VALUE at the 3rd edge after the pulse, CAPF=1, IRQ=1 with IRQ_EN=1.
